// File: rtl/rectify_pkg.sv
// Shared constants and FIFO entry type for the rectification read path.
package rectify_pkg;

    localparam int unsigned FRAC_BITS   = 4;
    localparam int unsigned COORD_INT_W = 10;
    localparam int unsigned PIX_W       = 8;

    // One rectified pixel plus its raster sideband.
    typedef struct packed {
        logic [PIX_W-1:0] pixel;
        logic             eol;
        logic             eof;
    } pix_entry_t;

endpackage

// File: rtl/img_buf_reader_if.sv
// Coordinate input stream and rectified pixel output stream.
interface img_buf_reader_if #(
    parameter int unsigned coord_w = rectify_pkg::COORD_INT_W + rectify_pkg::FRAC_BITS
);
    logic [coord_w-1:0] src_x;
    logic [coord_w-1:0] src_y;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         out_pixel;
    logic               out_eol;
    logic               out_eof;
    logic               out_valid;
    logic               out_ready;

    // Coordinate producer and pixel consumer side.
    modport master (
        output src_x, src_y, in_valid, out_ready,
        input  in_ready, out_pixel, out_eol, out_eof, out_valid
    );

    // Reader side.
    modport slave (
        input  src_x, src_y, in_valid, out_ready,
        output in_ready, out_pixel, out_eol, out_eof, out_valid
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO for pixel entries; head is visible whenever valid.
module sync_fifo_fwft
    import rectify_pkg::*;
#(
    parameter int unsigned depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  pix_entry_t               din,
    input  logic                     pop,
    output pix_entry_t               dout,
    output logic                     valid,
    output logic [$clog2(depth):0]   count
);

    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned NW = PW + 1;

    pix_entry_t        mem [depth];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;
    logic [NW-1:0]     count_nxt;

    // Qualify push/pop and compute the next occupancy.
    always_comb begin
        do_pop    = pop && valid;
        do_push   = push && ((count < NW'(depth)) || do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage, pointers and registered occupancy/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= 1'b0;
            for (int unsigned i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_nxt;
            valid <= (count_nxt != '0);
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/img_buf_reader.sv
// Read-side initiator for the four-bank image buffer: issues integer read
// coordinates, bilinearly interpolates the returned 2x2 neighbourhood and
// streams rectified pixels with raster sideband.
module img_buf_reader
    import rectify_pkg::*;
#(
    parameter int unsigned      img_width  = 8,
    parameter int unsigned      img_height = 8,
    parameter int unsigned      frac_bits  = FRAC_BITS,
    parameter logic [PIX_W-1:0] fill_value = 8'd0,
    parameter int unsigned      fifo_depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    img_buf_reader_if.slave        bus,
    output logic [COORD_INT_W-1:0] rx,
    output logic [COORD_INT_W-1:0] ry,
    input  logic [PIX_W-1:0]       lu,
    input  logic [PIX_W-1:0]       ru,
    input  logic [PIX_W-1:0]       ld,
    input  logic [PIX_W-1:0]       rd,
    output logic                   frame_done
);

    localparam int unsigned CW   = COORD_INT_W + frac_bits;
    localparam int unsigned WW   = frac_bits + 1;
    localparam int unsigned TW   = PIX_W + frac_bits;
    localparam int unsigned AW   = PIX_W + 2 * frac_bits;
    localparam int unsigned RW   = AW + 1;
    localparam int unsigned NW   = $clog2(fifo_depth) + 1;
    localparam int unsigned SW   = NW + 1;
    localparam int unsigned ONE  = 1 << frac_bits;
    localparam int unsigned HALF = 1 << (2 * frac_bits - 1);
    localparam logic [COORD_INT_W-1:0] X_LAST = COORD_INT_W'(img_width - 1);
    localparam logic [COORD_INT_W-1:0] Y_LAST = COORD_INT_W'(img_height - 1);

    logic                   in_ready_q;
    logic                   accept;
    logic [COORD_INT_W-1:0] xi;
    logic [COORD_INT_W-1:0] yi;
    logic [frac_bits-1:0]   fx0;
    logic [frac_bits-1:0]   fy0;
    logic                   oob0;
    logic                   eol0;
    logic                   eof0;
    logic [COORD_INT_W-1:0] col;
    logic [COORD_INT_W-1:0] row;
    logic [COORD_INT_W-1:0] col_base;
    logic [COORD_INT_W-1:0] row_base;
    logic [COORD_INT_W-1:0] rx_q;
    logic [COORD_INT_W-1:0] ry_q;

    logic                   v1, v2, v3;
    logic [frac_bits-1:0]   fx1, fx2;
    logic [frac_bits-1:0]   fy1, fy2, fy3;
    logic                   oob1, oob2, oob3;
    logic                   eol1, eol2, eol3;
    logic                   eof1, eof2, eof3;
    logic [WW-1:0]          wx;
    logic [WW-1:0]          wy;
    logic [TW-1:0]          top_c, bot_c;
    logic [TW-1:0]          top_q, bot_q;
    logic [AW-1:0]          acc;
    logic [RW-1:0]          rnd;
    logic [PIX_W-1:0]       pix_c;

    pix_entry_t             fifo_din;
    pix_entry_t             fifo_dout;
    logic                   fifo_valid;
    logic [NW-1:0]          fifo_count;
    logic                   pop;
    logic [NW-1:0]          flight;
    logic [NW-1:0]          flight_nxt;
    logic [NW-1:0]          count_nxt;
    logic                   credit_ok;

    assign accept       = bus.in_valid && in_ready_q;
    assign bus.in_ready = in_ready_q;

    // Issue stage: split the coordinate, apply edge clamps, drive the read address.
    always_comb begin
        xi       = bus.src_x[CW-1 -: COORD_INT_W];
        yi       = bus.src_y[CW-1 -: COORD_INT_W];
        oob0     = (xi >= COORD_INT_W'(img_width)) || (yi >= COORD_INT_W'(img_height));
        fx0      = (xi == X_LAST) ? '0 : bus.src_x[frac_bits-1:0];
        fy0      = (yi == Y_LAST) ? '0 : bus.src_y[frac_bits-1:0];
        col_base = frame_start ? '0 : col;
        row_base = frame_start ? '0 : row;
        eol0     = (col_base == X_LAST);
        eof0     = eol0 && (row_base == Y_LAST);
        rx       = rx_q;
        ry       = ry_q;
        if (accept) begin
            rx = oob0 ? '0 : xi;
            ry = oob0 ? '0 : yi;
        end
    end

    // Hold the last read address while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
            ry_q <= '0;
        end else begin
            rx_q <= rx;
            ry_q <= ry;
        end
    end

    // Raster counters: advance per accepted coordinate, cleared by frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= eol0 ? '0 : col_base + 1'b1;
            row <= eof0 ? '0 : (eol0 ? row_base + 1'b1 : row_base);
        end else begin
            col <= col_base;
            row <= row_base;
        end
    end

    // Horizontal blend of the neighbourhood arriving two cycles after issue.
    always_comb begin
        wx    = WW'(ONE) - WW'(fx2);
        top_c = TW'(lu) * TW'(wx) + TW'(ru) * TW'(fx2);
        bot_c = TW'(ld) * TW'(wx) + TW'(rd) * TW'(fx2);
    end

    // Vertical blend, round-to-nearest, saturate, substitute fill for out-of-range.
    always_comb begin
        wy    = WW'(ONE) - WW'(fy3);
        acc   = AW'(top_q) * AW'(wy) + AW'(bot_q) * AW'(fy3);
        rnd   = (RW'(acc) + RW'(HALF)) >> (2 * frac_bits);
        pix_c = (rnd > RW'(255)) ? '1 : rnd[PIX_W-1:0];
        if (oob3) begin
            pix_c = fill_value;
        end
        fifo_din.pixel = pix_c;
        fifo_din.eol   = eol3;
        fifo_din.eof   = eof3;
    end

    // Pipeline: carry fractions, oob and sideband alongside the buffer latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            fx1 <= '0; fx2 <= '0;
            fy1 <= '0; fy2 <= '0; fy3 <= '0;
            oob1 <= 1'b0; oob2 <= 1'b0; oob3 <= 1'b0;
            eol1 <= 1'b0; eol2 <= 1'b0; eol3 <= 1'b0;
            eof1 <= 1'b0; eof2 <= 1'b0; eof3 <= 1'b0;
            top_q <= '0;
            bot_q <= '0;
        end else begin
            v1   <= accept;  v2   <= v1;   v3   <= v2;
            fx1  <= fx0;     fx2  <= fx1;
            fy1  <= fy0;     fy2  <= fy1;  fy3  <= fy2;
            oob1 <= oob0;    oob2 <= oob1; oob3 <= oob2;
            eol1 <= eol0;    eol2 <= eol1; eol3 <= eol2;
            eof1 <= eof0;    eof2 <= eof1; eof3 <= eof2;
            top_q <= top_c;
            bot_q <= bot_c;
        end
    end

    sync_fifo_fwft #(
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (v3),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign pop           = fifo_valid && bus.out_ready;
    assign bus.out_pixel = fifo_dout.pixel;
    assign bus.out_eol   = fifo_dout.eol;
    assign bus.out_eof   = fifo_dout.eof;
    assign bus.out_valid = fifo_valid;

    // Credit check on next-cycle occupancy so the FIFO can never overflow.
    always_comb begin
        flight_nxt = flight + NW'(accept) - NW'(v3);
        count_nxt  = fifo_count + NW'(v3) - NW'(pop);
        credit_ok  = (SW'(flight_nxt) + SW'(count_nxt)) < SW'(fifo_depth);
    end

    // Credit state and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flight     <= '0;
            in_ready_q <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            flight     <= flight_nxt;
            in_ready_q <= credit_ok;
            frame_done <= pop && fifo_dout.eof;
        end
    end

endmodule
